// File: rtl/xbar_pipe.sv
// xbar_pipe: NUM_PORT x NUM_PORT crossbar with one register stage per output and all-or-nothing multicast.
// Optional macro XBAR_CONFLICT_CHECK_EN adds a sticky err_conflict flag for multi-grant columns.
module xbar_pipe #(
  parameter int NUM_PORT = 5,
  parameter int DATA_W   = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORT*NUM_PORT-1:0] alloc_vec,
  input  logic [NUM_PORT*DATA_W-1:0]   din,
  input  logic [NUM_PORT-1:0]          din_valid,
  output logic [NUM_PORT-1:0]          din_ready,
  output logic [NUM_PORT*DATA_W-1:0]   dout,
  output logic [NUM_PORT-1:0]          dout_valid,
  input  logic [NUM_PORT-1:0]          dout_ready,
  output logic                         err_conflict
);

  localparam int LOG_NUM_PORT = ($clog2(NUM_PORT) < 1) ? 1 : $clog2(NUM_PORT);

  logic [NUM_PORT-1:0]     win_valid;
  logic [LOG_NUM_PORT-1:0] win_idx  [NUM_PORT];
  logic [NUM_PORT-1:0]     grant    [NUM_PORT];
  logic [NUM_PORT-1:0]     out_free;
  logic [NUM_PORT-1:0]     xfer;
  logic [NUM_PORT-1:0]     load;
  logic [DATA_W-1:0]       sel_data [NUM_PORT];

  always_comb begin
    win_valid = '0;
    out_free  = '0;
    din_ready = '0;
    xfer      = '0;
    load      = '0;
    for (int j = 0; j < NUM_PORT; j++) begin
      win_idx[j]  = '0;
      sel_data[j] = '0;
      grant[j]    = '0;
    end

    // Scan downwards so the lowest-index requester is the last (winning) write.
    for (int j = 0; j < NUM_PORT; j++) begin
      for (int i = NUM_PORT - 1; i >= 0; i--) begin
        if (alloc_vec[i*NUM_PORT + j]) begin
          win_valid[j] = 1'b1;
          win_idx[j]   = LOG_NUM_PORT'(i);
        end
      end
      out_free[j] = !dout_valid[j] || dout_ready[j];
    end

    for (int i = 0; i < NUM_PORT; i++) begin
      for (int j = 0; j < NUM_PORT; j++) begin
        grant[i][j] = win_valid[j] && (win_idx[j] == LOG_NUM_PORT'(i));
      end
    end

    // An input only proceeds when every output it owns can take the flit.
    for (int i = 0; i < NUM_PORT; i++) begin
      din_ready[i] = !reset && (|grant[i]) && !(|(grant[i] & ~out_free));
      xfer[i]      = din_valid[i] && din_ready[i];
    end

    for (int j = 0; j < NUM_PORT; j++) begin
      for (int i = 0; i < NUM_PORT; i++) begin
        if (grant[i][j]) begin
          load[j]     = xfer[i];
          sel_data[j] = din[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_valid <= '0;
      dout       <= '0;
    end else begin
      for (int j = 0; j < NUM_PORT; j++) begin
        if (out_free[j]) begin
          dout_valid[j] <= load[j];
          if (load[j]) begin
            dout[j*DATA_W +: DATA_W] <= sel_data[j];
          end
        end
      end
    end
  end

`ifdef XBAR_CONFLICT_CHECK_EN
  logic                conflict;
  logic [NUM_PORT-1:0] col_seen;

  always_comb begin
    conflict = 1'b0;
    col_seen = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      for (int j = 0; j < NUM_PORT; j++) begin
        if (alloc_vec[i*NUM_PORT + j]) begin
          if (col_seen[j]) begin
            conflict = 1'b1;
          end
          col_seen[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_conflict <= 1'b0;
    end else if (conflict) begin
      err_conflict <= 1'b1;
    end
  end
`else
  assign err_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_xbar_pipe.sv
// Self-checking bench for xbar_pipe (NUM_PORT=5, DATA_W=16): vector table, corner sequences, random vs model.
module tb_xbar_pipe;
  localparam int N = 5;
  localparam int W = 16;
`ifdef XBAR_CONFLICT_CHECK_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N*N-1:0] alloc_vec;
  logic [N*W-1:0] din;
  logic [N-1:0]   din_valid;
  logic [N-1:0]   din_ready;
  logic [N*W-1:0] dout;
  logic [N-1:0]   dout_valid;
  logic [N-1:0]   dout_ready;
  logic           err_conflict;

  int checks = 0;
  int failures = 0;

  xbar_pipe #(.NUM_PORT(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .alloc_vec(alloc_vec), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [N*N-1:0] alloc;
    logic [N-1:0] dvalid;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_dv;
    logic [14:0]  exp_src;
    bit           conflict;
  } vec_t;

  vec_t tv [7];

  // reference model state
  logic [W-1:0] m_d [N];
  logic [N-1:0] m_dv;
  logic         m_err;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*N-1:0] g(input int i, input int j);
    logic [N*N-1:0] v;
    v = '0;
    v[i*N + j] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] dport(input int j);
    return dout[j*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) din[i*W +: W] = W'(base + W'(i));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alloc_vec = '0;
    din_valid = '0;
    dout_ready = '1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [N*N-1:0] perm;
    logic [2:0]     src;
    int             mw [N];
    logic [N-1:0]   er;
    logic [W-1:0]   nd [N];
    logic [N-1:0]   ndv;
    logic           nerr;
    int             cnt;
    bit             owns, ok;

    perm = g(0,1) | g(1,2) | g(2,3) | g(3,4) | g(4,0);
    tv[0] = '{"perm",      perm,                         5'b11111, 5'b11111, 5'b11111, {3'd3,3'd2,3'd1,3'd0,3'd4}, 1'b0};
    tv[1] = '{"ident",     g(0,0)|g(1,1)|g(2,2)|g(3,3)|g(4,4), 5'b10101, 5'b11111, 5'b10101, {3'd4,3'd3,3'd2,3'd1,3'd0}, 1'b0};
    tv[2] = '{"conflict",  g(0,2)|g(3,2),                5'b11111, 5'b00001, 5'b00100, {3'd0,3'd0,3'd0,3'd0,3'd0}, 1'b1};
    tv[3] = '{"mcast",     g(1,3)|g(1,4)|g(0,0),         5'b11111, 5'b00011, 5'b11001, {3'd1,3'd1,3'd0,3'd0,3'd0}, 1'b0};
    tv[4] = '{"empty",     '0,                           5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0};
    tv[5] = '{"bcast",     g(4,0)|g(4,1)|g(4,2)|g(4,3)|g(4,4), 5'b10000, 5'b10000, 5'b11111, {3'd4,3'd4,3'd4,3'd4,3'd4}, 1'b0};
    tv[6] = '{"lowwin",    g(2,1)|g(4,1)|g(4,3),         5'b10000, 5'b10100, 5'b01000, {3'd0,3'd4,3'd0,3'd0,3'd0}, 1'b1};

    reset = 1'b1;
    alloc_vec = '0;
    din = '0;
    din_valid = '0;
    dout_ready = '1;
    tick();
    tick();
    chk("rst_dout_valid", 80'(dout_valid), 80'(0));
    chk("rst_dout", 80'(dout), 80'(0));
    chk("rst_err", 80'(err_conflict), 80'(0));
    chk("rst_din_ready", 80'(din_ready), 80'(0));
    reset = 1'b0;

    // table-driven vectors, each from an empty pipeline
    for (int v = 0; v < 7; v++) begin
      do_reset();
      set_din(16'h1000);
      alloc_vec = tv[v].alloc;
      din_valid = tv[v].dvalid;
      #1;
      chk({tv[v].name, "_ready"}, 80'(din_ready), 80'(tv[v].exp_ready));
      tick();
      chk({tv[v].name, "_dv"}, 80'(dout_valid), 80'(tv[v].exp_dv));
      chk({tv[v].name, "_err"}, 80'(err_conflict), 80'(CC & tv[v].conflict));
      for (int j = 0; j < N; j++) begin
        if (tv[v].exp_dv[j]) begin
          src = tv[v].exp_src[j*3 +: 3];
          chk({tv[v].name, "_data"}, 80'(dport(j)), 80'(16'h1000 + 16'(src)));
        end
      end
    end

    // backpressure: input 2 -> output 0
    do_reset();
    alloc_vec = g(2,0);
    din[2*W +: W] = 16'hA000;
    din_valid = 5'b00100;
    #1;
    chk("bp_ready0", 80'(din_ready[2]), 80'(1));
    tick();
    din[2*W +: W] = 16'hA001;
    dout_ready = 5'b11110;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stall_ready", 80'(din_ready[2]), 80'(0));
      tick();
      chk("bp_hold_v", 80'(dout_valid[0]), 80'(1));
      chk("bp_hold_d", 80'(dport(0)), 80'(16'hA000));
    end
    dout_ready = '1;
    #1;
    chk("bp_resume_ready", 80'(din_ready[2]), 80'(1));
    tick();
    chk("bp_second_v", 80'(dout_valid[0]), 80'(1));
    chk("bp_second_d", 80'(dport(0)), 80'(16'hA001));
    din_valid = '0;
    tick();
    chk("bp_drain", 80'(dout_valid), 80'(0));

    // multicast stall: input 1 -> {3,4} with output 4 blocked
    do_reset();
    alloc_vec = g(0,4);
    din[0 +: W] = 16'hB000;
    din_valid = 5'b00001;
    tick();
    chk("mc_fill", 80'(dout_valid), 80'(5'b10000));
    dout_ready = 5'b01111;
    alloc_vec = g(1,3) | g(1,4);
    din[1*W +: W] = 16'hB111;
    din_valid = 5'b00010;
    #1;
    chk("mc_stall_ready", 80'(din_ready), 80'(0));
    tick();
    chk("mc_stall_dv", 80'(dout_valid), 80'(5'b10000));
    chk("mc_stall_d4", 80'(dport(4)), 80'(16'hB000));
    dout_ready = '1;
    #1;
    chk("mc_go_ready", 80'(din_ready), 80'(5'b00010));
    tick();
    chk("mc_go_dv", 80'(dout_valid), 80'(5'b11000));
    chk("mc_go_d3", 80'(dport(3)), 80'(16'hB111));
    chk("mc_go_d4", 80'(dport(4)), 80'(16'hB111));

    // sticky conflict flag, then mid-stream reset
    do_reset();
    set_din(16'h1000);
    alloc_vec = g(0,2) | g(3,2);
    din_valid = '1;
    tick();
    chk("cf_err", 80'(err_conflict), 80'(CC));
    alloc_vec = perm;
    #1;
    chk("cf_perm_ready", 80'(din_ready), 80'(5'b11111));
    tick();
    chk("cf_sticky", 80'(err_conflict), 80'(CC));
    chk("mr_full", 80'(dout_valid), 80'(5'b11111));
    dout_ready = '0;
    reset = 1'b1;
    #1;
    chk("mr_ready_in_rst", 80'(din_ready), 80'(0));
    tick();
    chk("mr_dv", 80'(dout_valid), 80'(0));
    chk("mr_err", 80'(err_conflict), 80'(0));
    chk("mr_dout", 80'(dout), 80'(0));
    reset = 1'b0;
    dout_ready = '1;
    set_din(16'hC000);
    #1;
    chk("mr_resume_ready", 80'(din_ready), 80'(5'b11111));
    tick();
    chk("mr_resume_dv", 80'(dout_valid), 80'(5'b11111));
    for (int i = 0; i < N; i++) chk("mr_resume_d", 80'(dport((i+1)%N)), 80'(16'hC000 + 16'(i)));

    // randomized traffic against the reference model
    do_reset();
    for (int j = 0; j < N; j++) m_d[j] = '0;
    m_dv = '0;
    m_err = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(39) == 0);
      for (int b = 0; b < N*N; b++) alloc_vec[b] = ($urandom_range(3) == 0);
      for (int i = 0; i < N; i++) begin
        din[i*W +: W] = W'($urandom);
        din_valid[i]  = ($urandom_range(9) < 7);
        dout_ready[i] = ($urandom_range(3) != 0);
      end

      for (int j = 0; j < N; j++) begin
        mw[j] = -1;
        for (int i = N - 1; i >= 0; i--) if (alloc_vec[i*N + j]) mw[j] = i;
      end
      for (int i = 0; i < N; i++) begin
        owns = 0;
        ok = 1;
        for (int j = 0; j < N; j++) begin
          if (mw[j] == i) begin
            owns = 1;
            if (m_dv[j] && !dout_ready[j]) ok = 0;
          end
        end
        er[i] = !reset && owns && ok;
      end

      ndv = m_dv;
      nerr = m_err;
      for (int j = 0; j < N; j++) nd[j] = m_d[j];
      if (reset) begin
        ndv = '0;
        nerr = 1'b0;
        for (int j = 0; j < N; j++) nd[j] = '0;
      end else begin
        for (int j = 0; j < N; j++) begin
          if (!m_dv[j] || dout_ready[j]) begin
            if (mw[j] >= 0 && din_valid[mw[j]] && er[mw[j]]) begin
              ndv[j] = 1'b1;
              nd[j]  = din[mw[j]*W +: W];
            end else begin
              ndv[j] = 1'b0;
            end
          end
          cnt = 0;
          for (int i = 0; i < N; i++) if (alloc_vec[i*N + j]) cnt++;
          if (CC && cnt > 1) nerr = 1'b1;
        end
      end

      #1;
      chk("rnd_ready", 80'(din_ready), 80'(er));
      tick();
      m_dv = ndv;
      m_err = nerr;
      for (int j = 0; j < N; j++) m_d[j] = nd[j];
      chk("rnd_dv", 80'(dout_valid), 80'(m_dv));
      chk("rnd_err", 80'(err_conflict), 80'(m_err));
      for (int j = 0; j < N; j++) if (m_dv[j]) chk("rnd_data", 80'(dport(j)), 80'(m_d[j]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xbar_pipe.md
XBAR_PIPE -- requirements
Module: xbar_pipe

Interface
REQ-001 The block SHALL have parameter NUM_PORT, default 5, giving the number of input ports and the number of output ports (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 64, giving the flit width in bits per port.
REQ-003 LOG_NUM_PORT SHALL be a localparam equal to clog2(NUM_PORT), minimum 1.
REQ-004 clk  input  1  Single clock; all state updates on the rising edge.
REQ-005 reset  input  1  Synchronous, active-high reset.
REQ-006 alloc_vec  input  NUM_PORT*NUM_PORT  Allocation matrix; bit [i*NUM_PORT+j]=1 grants input i to output j.
REQ-007 din  input  NUM_PORT*DATA_W  Input flits; port i occupies [i*DATA_W +: DATA_W].
REQ-008 din_valid  input  NUM_PORT  Per-input flit valid.
REQ-009 din_ready  output  NUM_PORT  Per-input accept, combinational from alloc_vec and output stage state.
REQ-010 dout  output  NUM_PORT*DATA_W  Registered output flits, same packing as din.
REQ-011 dout_valid  output  NUM_PORT  Per-output registered valid.
REQ-012 dout_ready  input  NUM_PORT  Per-output downstream accept.
REQ-013 err_conflict  output  1  Sticky allocation-conflict flag.

Function
REQ-014 Output j's winner SHALL be the lowest-index input i with alloc bit [i*NUM_PORT+j] set; output j has no winner when its column is all zero.
REQ-015 Output j is free when !dout_valid[j] || dout_ready[j].
REQ-016 din_ready[i] SHALL be 1 iff input i wins at least one output and every output it wins is free.
REQ-017 A transfer on input i occurs when din_valid[i] && din_ready[i], and the flit is delivered to every output that input i wins (multicast).
REQ-018 On a transfer, each receiving output register SHALL load din[i] and set dout_valid[j]=1 at the next edge, giving 1-cycle latency.
REQ-019 A free output with no transfer SHALL clear dout_valid[j] at the next edge, and its data is don't-care.
REQ-020 A non-free output (dout_valid=1, dout_ready=0) SHALL hold its data and valid unchanged.
REQ-021 Full throughput: with dout_ready held at 1, back-to-back transfers SHALL yield one flit per output per cycle with no bubbles.
REQ-022 alloc_vec MAY change on any cycle, and the routing decision uses only the value sampled in the transfer cycle.
REQ-023 An input granted no output SHALL see din_ready[i]=0, and its flit SHALL neither be dropped nor duplicated.
REQ-024 An input granted outputs where only some are free SHALL stall entirely, so no output ever receives a partial multicast.

Reset
REQ-025 While reset=1 at an edge, every dout_valid SHALL go to 0 and err_conflict SHALL go to 0, and dout SHALL be reset to all zeros.
REQ-026 A reset arriving mid-stream SHALL discard held flits, and no transfer SHALL be counted in the reset cycle.
REQ-027 din_ready SHALL be 0 for all inputs during any cycle in which reset=1.

Configuration
REQ-028 Macro XBAR_CONFLICT_CHECK_EN, when defined, SHALL set err_conflict at the next edge whenever any alloc_vec column has more than one bit set, and the flag SHALL hold until reset.
REQ-029 When XBAR_CONFLICT_CHECK_EN is undefined, err_conflict SHALL be tied to 0, and no conflict detection logic SHALL be present.
REQ-030 Winner selection per REQ-014 SHALL be identical with or without the macro.

Verification (NUM_PORT=5, DATA_W=16)
REQ-031 Permutation: alloc maps i->(i+1)%5, din[i]=16'h1000+i, all valid, all dout_ready=1 -> the next cycle gives dout[(i+1)%5]=16'h1000+i with all dout_valid=1.
REQ-032 Backpressure: input 2->output 0 with dout_ready[0]=0 for 3 cycles -> dout[0] holds the first flit, din_ready[2]=0 for those 3 cycles, and no flit is lost after ready returns.
REQ-033 Multicast stall: input 1->outputs {3,4} with output 4 blocked -> din_ready[1]=0, and neither output 3 nor output 4 loads.
REQ-034 Conflict: alloc bits for inputs 0 and 3 both set on output 2 -> input 0 wins, din_ready[3]=0, and err_conflict=1 the next cycle with the macro (stays 0 without it).
REQ-035 Mid-stream reset: reset=1 while dout_valid=5'b11111 -> dout_valid=0 and err_conflict=0 the next cycle, and traffic resumes correctly the cycle after reset is deasserted.
